// File: rtl/hps_ext_bridge_pkg.sv
`default_nettype none
// ============================================================================
// hps_ext_pkg
// Shared constants, command classes and command decoder for hps_ext_bridge.
// Revision: 1.0 - initial release
// ============================================================================
package hps_ext_pkg;

  // Word counter width; the counter saturates at its all-ones value.
  localparam int unsigned     CNT_W   = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Tag placed in the upper byte of the header reply word.
  localparam logic [7:0] HDR_TAG = 8'hC0;

  // Offsets within a channel's command pair.
  localparam int unsigned OFF_WR = 0;
  localparam int unsigned OFF_RD = 1;
  // Offsets after the block of 2*NCH channel commands.
  localparam int unsigned OFF_CTRL = 0;
  localparam int unsigned OFF_STAT = 1;

  typedef enum logic [2:0] {
    CMD_NONE = 3'd0,
    CMD_WR   = 3'd1,
    CMD_RD   = 3'd2,
    CMD_CTRL = 3'd3,
    CMD_STAT = 3'd4
  } cmd_cls_e;

  typedef struct packed {
    cmd_cls_e   cls;
    logic [2:0] ch;
  } cmd_dec_t;

  // Map a 16-bit command code onto a class and channel index.
  function automatic cmd_dec_t decode_cmd(input logic [15:0] code,
                                          input logic [15:0] base,
                                          input int unsigned nch);
    cmd_dec_t    r;
    logic [16:0] off;
    r.cls = CMD_NONE;
    r.ch  = 3'd0;
    off   = {1'b0, code} - {1'b0, base};
    if (code >= base) begin
      if (off < 17'(2 * nch)) begin
        r.ch  = off[3:1];
        r.cls = (off[0] == 1'(OFF_RD)) ? CMD_RD : CMD_WR;
      end else if (off == 17'(2 * nch + OFF_CTRL)) begin
        r.cls = CMD_CTRL;
      end else if (off == 17'(2 * nch + OFF_STAT)) begin
        r.cls = CMD_STAT;
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hps_ext_bridge_if.sv
`default_nettype none
// ============================================================================
// hps_ext_bridge_if
// HPS EXT_BUS fields: [15:0] io_dout, [31:16] io_din, [32] dout_en,
// [33] io_strobe, [35:34] io_enable. The HPS is the master.
// Revision: 1.0 - initial release
// ============================================================================
interface hps_ext_bridge_if;
  logic [15:0] io_dout;
  logic [15:0] io_din;
  logic        dout_en;
  logic        io_strobe;
  logic [1:0]  io_enable;

  modport master (output io_din, io_strobe, io_enable,
                  input  io_dout, dout_en);
  modport slave  (input  io_din, io_strobe, io_enable,
                  output io_dout, dout_en);
endinterface
`default_nettype wire

// File: rtl/hps_ext_bridge_rdbuf.sv
`default_nettype none
// ============================================================================
// hps_ext_rdbuf
// One-entry read prefetch holder with outstanding-read tracking, same-cycle
// bypass of returning data, and a sticky overrun flag with clear-on-read.
// Revision: 1.0 - initial release
// ============================================================================
module hps_ext_rdbuf (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,    // transaction aborted: drop holder and pending read
  input  logic        issue_i,    // a read request is being launched
  input  logic        rvalid_i,
  input  logic [15:0] rdata_i,
  input  logic        take_i,     // HPS is consuming a data word
  input  logic        ovr_clr_i,  // status read clears the sticky flag
  output logic        hit_o,      // data available for take_i this cycle
  output logic [15:0] data_o,
  output logic        overrun_o
);

  logic        full_q, full_d;
  logic        outst_q, outst_d;
  logic        ovr_q, ovr_d;
  logic [15:0] hold_q, hold_d;
  logic        capture;

  // Returning data only counts while a read is actually outstanding.
  assign capture   = rvalid_i & outst_q;
  assign hit_o     = full_q | capture;
  assign data_o    = full_q ? hold_q : rdata_i;
  assign overrun_o = ovr_q;

  // Next-state for holder, outstanding flag and overrun.
  always_comb begin
    full_d  = full_q;
    outst_d = outst_q;
    ovr_d   = ovr_q;
    hold_d  = hold_q;
    if (capture) begin
      outst_d = 1'b0;
      // A capture coinciding with a take is forwarded, not stored.
      if (!take_i) begin
        full_d = 1'b1;
        hold_d = rdata_i;
      end
    end
    if (take_i && full_q) begin
      full_d = 1'b0;
    end
    if (ovr_clr_i) begin
      ovr_d = 1'b0;
    end
    if (take_i && !hit_o) begin
      ovr_d = 1'b1;
    end
    if (issue_i) begin
      outst_d = 1'b1;
    end
    if (flush_i) begin
      full_d  = 1'b0;
      outst_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q  <= 1'b0;
      outst_q <= 1'b0;
      ovr_q   <= 1'b0;
      hold_q  <= 16'd0;
    end else begin
      full_q  <= full_d;
      outst_q <= outst_d;
      ovr_q   <= ovr_d;
      hold_q  <= hold_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hps_ext_bridge.sv
`default_nettype none
// ============================================================================
// hps_ext_bridge
// Decodes HPS EXT_BUS command transactions into core-side register/memory
// accesses: per-channel write/read bursts, a control word and a status word.
// Revision: 1.0 - initial release
// ============================================================================
module hps_ext_bridge
  import hps_ext_pkg::*;
#(
  parameter int unsigned DW       = 16,
  parameter int unsigned AW       = 16,
  parameter int unsigned NCH      = 2,
  parameter logic [15:0] CMD_BASE = 16'h0061,
  parameter int unsigned REQ_W    = 8,
  parameter bit          AUTOINC  = 1'b1
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  hps_ext_bridge_if.slave  EXT_BUS,
  input  logic [DW-1:0]    ext_din,
  input  logic             ext_rvalid,
  output logic [DW-1:0]    ext_dout,
  output logic [AW-1:0]    ext_addr,
  output logic [2:0]       ext_ch,
  output logic             ext_rd,
  output logic             ext_wr,
  output logic             ext_active,
  output logic [15:0]      ext_ctrl,
  input  logic [REQ_W-1:0] ext_req
);

  logic              enable;
  cmd_dec_t          dec;
  logic [15:0]       din_ext;
  logic [7:0]        req_ext;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  cmd_cls_e          cls_q, cls_d;
  logic [2:0]        ch_q, ch_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     dout_q, dout_d;
  logic              wr_q, wr_d;
  logic              rd_q, rd_d;
  logic              act_q, act_d;
  logic [15:0]       ctrl_q, ctrl_d;
  logic [15:0]       iodout_q, iodout_d;
  logic              douten_q, douten_d;

  logic              rb_take, rb_flush, rb_ovr_clr, rb_hit, rb_ovr;
  logic [15:0]       rb_data;

  assign enable  = |EXT_BUS.io_enable;
  assign dec     = decode_cmd(EXT_BUS.io_din, CMD_BASE, NCH);
  assign din_ext = 16'(ext_din);
  assign req_ext = 8'(ext_req);

  hps_ext_rdbuf u_rdbuf (
    .clk_i     (clk_sys),
    .rst_ni    (reset_n),
    .flush_i   (rb_flush),
    .issue_i   (rd_d),
    .rvalid_i  (ext_rvalid),
    .rdata_i   (din_ext),
    .take_i    (rb_take),
    .ovr_clr_i (rb_ovr_clr),
    .hit_o     (rb_hit),
    .data_o    (rb_data),
    .overrun_o (rb_ovr)
  );

  // Transaction sequencing: word counter, command class and all outputs.
  always_comb begin
    cnt_d      = cnt_q;
    cls_d      = cls_q;
    ch_d       = ch_q;
    addr_d     = addr_q;
    dout_d     = dout_q;
    wr_d       = 1'b0;
    rd_d       = 1'b0;
    act_d      = act_q;
    ctrl_d     = ctrl_q;
    iodout_d   = iodout_q;
    douten_d   = douten_q;
    rb_take    = 1'b0;
    rb_flush   = 1'b0;
    rb_ovr_clr = 1'b0;

    // Post-write increment lands the cycle after the ext_wr pulse.
    if (AUTOINC && wr_q) begin
      addr_d = addr_q + AW'(1);
    end

    if (!enable) begin
      cnt_d    = '0;
      cls_d    = CMD_NONE;
      act_d    = 1'b0;
      iodout_d = 16'd0;
      douten_d = 1'b0;
      rb_flush = 1'b1;
    end else if (EXT_BUS.io_strobe) begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (cnt_q == CNT_W'(0)) begin
        // Header: latch the command; unknown codes stay silent.
        cls_d = dec.cls;
        if (dec.cls != CMD_NONE) begin
          ch_d     = dec.ch;
          douten_d = 1'b1;
          iodout_d = {HDR_TAG, req_ext};
        end
      end else if (cnt_q == CNT_W'(1)) begin
        case (cls_q)
          CMD_WR: addr_d = EXT_BUS.io_din[AW-1:0];
          CMD_RD: begin
            addr_d = EXT_BUS.io_din[AW-1:0];
            rd_d   = 1'b1;
          end
          CMD_CTRL: ctrl_d = EXT_BUS.io_din;
          CMD_STAT: begin
            iodout_d   = {rb_ovr, 15'd0};
            rb_ovr_clr = 1'b1;
          end
          default: ;
        endcase
      end else begin
        if (cls_q != CMD_NONE) begin
          act_d = 1'b1;
        end
        case (cls_q)
          CMD_WR: begin
            dout_d = EXT_BUS.io_din[DW-1:0];
            wr_d   = 1'b1;
          end
          CMD_RD: begin
            rb_take = 1'b1;
            if (rb_hit) begin
              // Hand over the prefetched word and launch the next prefetch.
              iodout_d = rb_data;
              rd_d     = 1'b1;
              if (AUTOINC) begin
                addr_d = addr_q + AW'(1);
              end
            end else begin
              iodout_d = 16'hFFFF;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // State registers.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      cls_q    <= CMD_NONE;
      ch_q     <= 3'd0;
      addr_q   <= '0;
      dout_q   <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      act_q    <= 1'b0;
      ctrl_q   <= 16'd0;
      iodout_q <= 16'd0;
      douten_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      cls_q    <= cls_d;
      ch_q     <= ch_d;
      addr_q   <= addr_d;
      dout_q   <= dout_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      act_q    <= act_d;
      ctrl_q   <= ctrl_d;
      iodout_q <= iodout_d;
      douten_q <= douten_d;
    end
  end

  assign ext_dout        = dout_q;
  assign ext_addr        = addr_q;
  assign ext_ch          = ch_q;
  assign ext_rd          = rd_q;
  assign ext_wr          = wr_q;
  assign ext_active      = act_q;
  assign ext_ctrl        = ctrl_q;
  assign EXT_BUS.io_dout = iodout_q;
  assign EXT_BUS.dout_en = douten_q;

endmodule
`default_nettype wire

// File: tb/tb_hps_ext_bridge.sv
`default_nettype none
// ============================================================================
// tb_hps_ext_bridge
// Randomised scoreboard bench for hps_ext_bridge with a core-side responder.
// Revision: 1.0 - initial release
// ============================================================================
module tb_hps_ext_bridge;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [15:0] ext_din;
  logic        ext_rvalid;
  logic [15:0] ext_dout;
  logic [15:0] ext_addr;
  logic [2:0]  ext_ch;
  logic        ext_rd;
  logic        ext_wr;
  logic        ext_active;
  logic [15:0] ext_ctrl;
  logic [7:0]  ext_req;

  hps_ext_bridge_if bus ();

  hps_ext_bridge #(
    .DW(16), .AW(16), .NCH(2), .CMD_BASE(16'h0061), .REQ_W(8), .AUTOINC(1'b1)
  ) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .EXT_BUS    (bus),
    .ext_din    (ext_din),
    .ext_rvalid (ext_rvalid),
    .ext_dout   (ext_dout),
    .ext_addr   (ext_addr),
    .ext_ch     (ext_ch),
    .ext_rd     (ext_rd),
    .ext_wr     (ext_wr),
    .ext_active (ext_active),
    .ext_ctrl   (ext_ctrl),
    .ext_req    (ext_req)
  );

  always #5 clk_sys = ~clk_sys;

  int checks   = 0;
  int failures = 0;

  typedef struct packed { logic chk; logic [15:0] dout; logic en; } hexp_t;
  typedef struct packed { logic [15:0] addr; logic [15:0] data; logic [2:0] ch; } wexp_t;
  typedef struct { int due; logic [15:0] data; } rsp_t;

  hexp_t hq[$];
  wexp_t wq[$];
  rsp_t  rq[$];

  int          cyc    = 0;
  int          lat    = 2;
  int          rd_cnt = 0;
  logic [15:0] key    = 16'h0000;
  logic        ovr_model = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Core-side responder: answers each ext_rd after `lat` cycles with addr^key.
  initial begin
    rsp_t r;
    ext_rvalid = 1'b0;
    ext_din    = 16'd0;
    forever begin
      @(negedge clk_sys);
      cyc++;
      ext_rvalid = 1'b0;
      if (rq.size() > 0 && rq[0].due <= cyc) begin
        r = rq.pop_front();
        ext_rvalid = 1'b1;
        ext_din    = r.data;
      end
      if (ext_rd) begin
        rd_cnt++;
        r.due  = cyc + lat;
        r.data = ext_addr ^ key;
        rq.push_back(r);
      end
    end
  end

  // HPS-side monitor: one expectation per strobe, compared after the edge.
  initial begin
    hexp_t e;
    forever begin
      @(posedge clk_sys);
      if (reset_n && bus.io_strobe && bus.io_enable != 2'b00) begin
        @(negedge clk_sys);
        if (hq.size() == 0) begin
          check("hps_sb_underflow", 32'd0, 32'd1);
        end else begin
          e = hq.pop_front();
          check("dout_en", {31'd0, bus.dout_en}, {31'd0, e.en});
          if (e.chk) check("io_dout", {16'd0, bus.io_dout}, {16'd0, e.dout});
        end
      end
    end
  end

  // Core-side write monitor.
  initial begin
    wexp_t w;
    forever begin
      @(negedge clk_sys);
      if (reset_n && ext_wr) begin
        if (wq.size() == 0) begin
          check("unexpected_ext_wr", {16'd0, ext_addr}, 32'hFFFF_FFFF);
        end else begin
          w = wq.pop_front();
          check("wr_addr", {16'd0, ext_addr}, {16'd0, w.addr});
          check("wr_data", {16'd0, ext_dout}, {16'd0, w.data});
          check("wr_ch", {29'd0, ext_ch}, {29'd0, w.ch});
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic hstrobe(input logic [15:0] din, input logic chk,
                         input logic [15:0] dout, input logic en, input int gap);
    hexp_t e;
    e.chk = chk; e.dout = dout; e.en = en;
    @(negedge clk_sys);
    hq.push_back(e);
    bus.io_din    = din;
    bus.io_strobe = 1'b1;
    @(negedge clk_sys);
    bus.io_strobe = 1'b0;
    idle(gap);
  endtask

  task automatic txn_begin();
    @(negedge clk_sys);
    ext_req       = 8'($urandom);
    bus.io_enable = 2'b11;
  endtask

  task automatic txn_end();
    @(negedge clk_sys);
    bus.io_enable = 2'b00;
    bus.io_strobe = 1'b0;
    idle(2);
  endtask

  function automatic logic [15:0] hdr();
    return {8'hC0, ext_req};
  endfunction

  task automatic do_write(input int ch, input logic [15:0] a, input int n);
    wexp_t w;
    logic [15:0] d;
    txn_begin();
    hstrobe(16'h0061 + 16'(2 * ch), 1'b1, hdr(), 1'b1, 1);
    hstrobe(a, 1'b0, 16'd0, 1'b1, 1);
    for (int i = 0; i < n; i++) begin
      d = 16'($urandom);
      w.addr = a + 16'(i); w.data = d; w.ch = 3'(ch);
      wq.push_back(w);
      hstrobe(d, 1'b0, 16'd0, 1'b1, 2);
    end
    idle(2);
    check("write_active", {31'd0, ext_active}, 32'd1);
    txn_end();
    check("active_after_end", {31'd0, ext_active}, 32'd0);
  endtask

  task automatic do_read(input int ch, input logic [15:0] a, input int n, input logic [15:0] k);
    key = k;
    lat = $urandom_range(1, 4);
    txn_begin();
    hstrobe(16'h0062 + 16'(2 * ch), 1'b1, hdr(), 1'b1, 1);
    hstrobe(a, 1'b0, 16'd0, 1'b1, 8);
    for (int i = 0; i < n; i++) begin
      hstrobe(16'd0, 1'b1, (a + 16'(i)) ^ k, 1'b1, 8);
    end
    check("read_active", {31'd0, ext_active}, 32'd1);
    txn_end();
    idle(8);
  endtask

  task automatic do_status();
    txn_begin();
    hstrobe(16'h0066, 1'b1, hdr(), 1'b1, 1);
    hstrobe(16'd0, 1'b1, {ovr_model, 15'd0}, 1'b1, 1);
    ovr_model = 1'b0;
    txn_end();
  endtask

  task automatic do_ctrl(input logic [15:0] v);
    int r0;
    r0 = rd_cnt;
    txn_begin();
    hstrobe(16'h0065, 1'b1, hdr(), 1'b1, 1);
    hstrobe(v, 1'b0, 16'd0, 1'b1, 3);
    txn_end();
    check("ext_ctrl", {16'd0, ext_ctrl}, {16'd0, v});
    check("ctrl_no_rd", rd_cnt, r0);
  endtask

  task automatic do_invalid(input logic [15:0] code);
    int r0;
    r0 = rd_cnt;
    txn_begin();
    hstrobe(code, 1'b1, 16'd0, 1'b0, 1);
    hstrobe(16'h1234, 1'b1, 16'd0, 1'b0, 2);
    hstrobe(16'h5678, 1'b1, 16'd0, 1'b0, 2);
    hstrobe(16'h9ABC, 1'b1, 16'd0, 1'b0, 4);
    check("invalid_active", {31'd0, ext_active}, 32'd0);
    txn_end();
    check("invalid_no_rd", rd_cnt, r0);
  endtask

  initial begin
    logic [15:0] a;
    bit found;
    reset_n       = 1'b0;
    bus.io_din    = 16'd0;
    bus.io_strobe = 1'b0;
    bus.io_enable = 2'b00;
    ext_req       = 8'h5A;
    idle(3);
    check("reset_outputs",
          {ext_dout[7:0], ext_addr[7:0], ext_ch, ext_rd, ext_wr, ext_active, bus.dout_en, 1'b0},
          32'd0);
    check("reset_io_dout_ctrl", {bus.io_dout, ext_ctrl}, 32'd0);
    reset_n = 1'b1;
    idle(2);

    // Header with a fixed request byte.
    bus.io_enable = 2'b11;
    hstrobe(16'h0061, 1'b1, 16'hC05A, 1'b1, 1);
    txn_end();
    do_invalid(16'h0070);

    // Write burst on channel 1.
    do_write(1, 16'h0100, 3);
    // Read burst and address wrap.
    do_read(0, 16'h00FF, 2, 16'hA5A5);
    do_read(1, 16'hFFFF, 2, 16'h3C3C);

    // Overrun: response held off 20 cycles.
    key = 16'h0F0F; lat = 20;
    txn_begin();
    hstrobe(16'h0062, 1'b1, hdr(), 1'b1, 1);
    hstrobe(16'h0200, 1'b0, 16'd0, 1'b1, 2);
    hstrobe(16'd0, 1'b1, 16'hFFFF, 1'b1, 25);
    ovr_model = 1'b1;
    hstrobe(16'd0, 1'b1, 16'h0200 ^ 16'h0F0F, 1'b1, 2);
    txn_end();
    idle(25);
    do_status();
    do_status();

    // Data returning on the same cycle as the strobe.
    key = 16'h7777; lat = 3;
    a   = 16'h0400;
    txn_begin();
    hstrobe(16'h0064, 1'b1, hdr(), 1'b1, 1);
    hstrobe(a, 1'b0, 16'd0, 1'b1, 0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk_sys);
      #1;
      if (ext_rvalid) found = 1'b1;
    end
    check("collision_rvalid_seen", {31'd0, found}, 32'd1);
    if (found) begin
      hq.push_back('{chk: 1'b1, dout: a ^ 16'h7777, en: 1'b1});
      bus.io_din    = 16'd0;
      bus.io_strobe = 1'b1;
      @(negedge clk_sys);
      bus.io_strobe = 1'b0;
      idle(8);
      hstrobe(16'd0, 1'b1, (a + 16'd1) ^ 16'h7777, 1'b1, 4);
    end
    txn_end();
    idle(8);
    do_status();

    // Abort with a read outstanding; the late response must be dropped.
    key = 16'hDEAD; lat = 6;
    txn_begin();
    hstrobe(16'h0062, 1'b1, hdr(), 1'b1, 1);
    hstrobe(16'h0300, 1'b0, 16'd0, 1'b1, 1);
    txn_end();
    check("abort_active", {31'd0, ext_active}, 32'd0);
    idle(10);
    do_read(0, 16'h0500, 2, 16'hBEEF);

    do_ctrl(16'h0080);

    // Randomised mix.
    for (int t = 0; t < 14; t++) begin
      case ($urandom_range(0, 3))
        0: do_write($urandom_range(0, 1), 16'($urandom), $urandom_range(1, 4));
        1: do_read($urandom_range(0, 1), 16'($urandom), $urandom_range(1, 4), 16'($urandom));
        2: do_invalid(($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 16'h0060))
                                                   : 16'($urandom_range(16'h0067, 16'hFFFF)));
        default: do_ctrl(16'($urandom));
      endcase
    end

    idle(10);
    check("hps_queue_drained", hq.size(), 0);
    check("wr_queue_drained", wq.size(), 0);

    // Asynchronous reset in the middle of a write burst.
    do_ctrl(16'h0080);
    txn_begin();
    hstrobe(16'h0063, 1'b1, hdr(), 1'b1, 1);
    hstrobe(16'h0700, 1'b0, 16'd0, 1'b1, 1);
    wq.push_back('{addr: 16'h0700, data: 16'hCAFE, ch: 3'd1});
    hstrobe(16'hCAFE, 1'b0, 16'd0, 1'b1, 3);
    check("pre_reset_active", {31'd0, ext_active}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("reset_mid_outputs",
          {ext_ch, ext_rd, ext_wr, ext_active, bus.dout_en, 27'd0}, 32'd0);
    check("reset_mid_addr_dout", {ext_addr, ext_dout}, 32'd0);
    check("reset_mid_ctrl_iodout", {ext_ctrl, bus.io_dout}, 32'd0);
    bus.io_enable = 2'b00;
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
